// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is produced per CALC cycle. A FIX cycle applies the sign
// correction and the divide-by-zero / signed-overflow results. The final
// DONE cycle presents the registered result together with a one-cycle done pulse.
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_in,
    input  logic [1:0]   op_in,
    input  logic [N-1:0] A_in,
    input  logic [N-1:0] B_in,
    output logic         busy_out,
    output logic         done_out,
    output logic [N-1:0] result_out
);

    // Counter must hold the value N itself, hence the extra bit.
    localparam int CW = $clog2(N) + 1;
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Operation bookkeeping captured at start.
    // op[0] = 1 selects unsigned, op[1] = 1 selects remainder.
    logic [1:0]    op_q;
    logic [N-1:0]  a_orig;
    logic [N-1:0]  b_orig;
    logic [N-1:0]  b_mag;
    logic          sign_a;
    logic          sign_b;

    // Iteration registers: partial remainder R (N+1 bits) and quotient/dividend Q.
    logic [N:0]    rem_q;
    logic [N-1:0]  quo_q;
    logic [CW-1:0] count;

    // Operand preparation for the start cycle.
    logic          in_sign_a;
    logic          in_sign_b;
    logic [N-1:0]  in_mag_a;
    logic [N-1:0]  in_mag_b;

    // One restoring step.
    logic [2*N:0]  shift_pair;
    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic          trial_ok;
    logic [N-1:0]  quo_step;
    logic          calc_last;

    // Final result selection.
    logic [N-1:0]  rem_low;
    logic [N-1:0]  quo_final;
    logic [N-1:0]  rem_final;
    logic          div_by_zero;
    logic          signed_ovf;
    logic [N-1:0]  fix_result;

    // Signed ops record operand signs and use magnitudes.
    // Unsigned ops pass operands through with the signs cleared.
    // The magnitude of the most negative value wraps to 2^(N-1), which is
    // exactly the unsigned value wanted.
    always_comb begin
        in_sign_a = ~op_in[0] & A_in[N-1];
        in_sign_b = ~op_in[0] & B_in[N-1];
        in_mag_a  = in_sign_a ? (-A_in) : A_in;
        in_mag_b  = in_sign_b ? (-B_in) : B_in;
    end

    // Shift {R,Q} left by one and trial-subtract the divisor from the new R.
    // Because R < |B| before the shift, the shifted R is below 2|B|. The N+1-bit
    // difference therefore never overflows, and its top bit is a true sign bit.
    always_comb begin
        shift_pair = {rem_q, quo_q} << 1;
        shifted    = shift_pair[2*N:N];
        trial      = shifted - {1'b0, b_mag};
        trial_ok   = ~trial[N];
        quo_step   = shift_pair[N-1:0] | {{(N-1){1'b0}}, trial_ok};
        calc_last  = (count == CW'(1));
    end

    // Sign correction plus the special cases.
    // Divide-by-zero takes precedence over signed overflow, and both override
    // the value the iteration produced.
    always_comb begin
        rem_low     = rem_q[N-1:0];
        quo_final   = (sign_a ^ sign_b) ? (-quo_q) : quo_q;
        rem_final   = sign_a ? (-rem_low) : rem_low;
        div_by_zero = (b_orig == '0);
        signed_ovf  = ~op_q[0] & (a_orig == MIN_VAL) & (b_orig == '1);
        if (div_by_zero) begin
            fix_result = op_q[1] ? a_orig : '1;
        end else if (signed_ovf) begin
            fix_result = op_q[1] ? '0 : a_orig;
        end else begin
            fix_result = op_q[1] ? rem_final : quo_final;
        end
    end

    // State register. Reset returns to IDLE from any state, aborting the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs.
    // busy covers CALC, FIX and DONE; done is high in DONE only.
    always_comb begin
        state_next = state;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy_out = 1'b1;
                if (calc_last) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy_out   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                busy_out   = 1'b1;
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: capture operands in IDLE, iterate in CALC, and
    // register the result in FIX so that it is stable from DONE until the next FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            a_orig     <= '0;
            b_orig     <= '0;
            b_mag      <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            count      <= '0;
            result_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        op_q   <= op_in;
                        a_orig <= A_in;
                        b_orig <= B_in;
                        sign_a <= in_sign_a;
                        sign_b <= in_sign_b;
                        b_mag  <= in_mag_b;
                        quo_q  <= in_mag_a;
                        rem_q  <= '0;
                        count  <= CW'(N);
                    end
                end
                CALC: begin
                    rem_q <= trial_ok ? trial : shifted;
                    quo_q <= quo_step;
                    count <= count - CW'(1);
                end
                FIX: begin
                    result_out <= fix_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven and scoreboarded checks of seq_divider (N=32).
// Expected results are queued when an operation is launched and are compared when
// done_out fires. Latency, busy duration and the control corner cases are also checked.
module tb_seq_divider;

    localparam int N   = 32;
    localparam int LAT = N + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_in;
    logic [1:0]   op_in;
    logic [N-1:0] A_in;
    logic [N-1:0] B_in;
    logic         busy_out;
    logic         done_out;
    logic [N-1:0] result_out;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] scoreboard[$];
    int          n_vectors     = 0;
    int          n_miscompares = 0;

    seq_divider #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .op_in      (op_in),
        .A_in       (A_in),
        .B_in       (B_in),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .result_out (result_out)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Compare one observed value against its required value.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Reference results: truncating signed division, and a remainder that takes the dividend's sign.
    function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sbv;
        sa  = a;
        sbv = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
        case (op)
            2'b00:   return 32'(sa / sbv);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sbv);
            default: return a % b;
        endcase
    endfunction

    // Count done pulses over a window; used where no result may appear.
    task automatic countDone(input int window, output int pulses);
        pulses = 0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (done_out) pulses++;
        end
    endtask

    // Launch one operation and follow it to completion.
    // glitch_cycle > 0 pulses start_in (with other operands) during that cycle of the operation.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expected, input string name, input int glitch_cycle);
        int          cycles;
        int          busy_cycles;
        logic        got;
        logic [31:0] want;
        @(negedge clk);
        start_in = 1'b1;
        op_in    = op;
        A_in     = a;
        B_in     = b;
        scoreboard.push_back(expected);
        @(negedge clk);
        start_in    = 1'b0;
        A_in        = $urandom();
        B_in        = $urandom();
        op_in       = 2'($urandom_range(0, 3));
        cycles      = 0;
        busy_cycles = 0;
        got         = 1'b0;
        want        = expected;
        while (!got && cycles < 4 * LAT) begin
            cycles++;
            if (busy_out) busy_cycles++;
            if (done_out) begin
                got = 1'b1;
                if (scoreboard.size() == 0) begin
                    checkOutput({name, " unexpected done"}, 32'd1, 32'd0);
                end else begin
                    want = scoreboard.pop_front();
                    checkOutput({name, " result"}, result_out, want);
                end
            end else begin
                start_in = (glitch_cycle != 0) && (cycles == glitch_cycle);
                @(negedge clk);
            end
        end
        start_in = 1'b0;
        checkOutput({name, " done seen"}, {31'd0, got}, 32'd1);
        checkOutput({name, " latency"}, 32'(cycles), 32'(LAT));
        checkOutput({name, " busy cycles"}, 32'(busy_cycles), 32'(LAT));
        @(negedge clk);
        checkOutput({name, " busy after done"}, {31'd0, busy_out}, 32'd0);
        checkOutput({name, " done after done"}, {31'd0, done_out}, 32'd0);
        checkOutput({name, " result held"}, result_out, want);
    endtask

    // Main test sequence.
    initial begin
        int          pulses;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         "DIVU 100/7"});
        vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          "REMU 100/7"});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "DIV -7/2"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "REM -7/2"});
        vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          "REM 7/-2"});
        vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  "DIV 7/-2"});
        vecs.push_back('{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         "DIV -100/-7"});
        vecs.push_back('{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  "REM -100/-7"});
        vecs.push_back('{2'b00, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  "DIV by zero"});
        vecs.push_back('{2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  "DIVU by zero"});
        vecs.push_back('{2'b10, 32'h1234_5678,  32'd0,          32'h1234_5678,  "REM by zero"});
        vecs.push_back('{2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678,  "REMU by zero"});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "DIV overflow"});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "REM overflow"});
        // Unsigned view of the same bits: 2^31 / (2^32-1) is 0, leaving 2^31 as the remainder.
        vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "DIVU min/ones"});
        vecs.push_back('{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "REMU min/ones"});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  "DIV min/2"});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  "DIVU ones/1"});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'd10,         32'd5,          "REMU ones/10"});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  "DIVU ones/10"});
        vecs.push_back('{2'b11, 32'd5,          32'd9,          32'd5,          "REMU 5/9"});
        vecs.push_back('{2'b01, 32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_DEAD,  "DIVU deadbeef"});
        vecs.push_back('{2'b11, 32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_BEEF,  "REMU deadbeef"});

        rst      = 1'b1;
        start_in = 1'b0;
        op_in    = 2'b00;
        A_in     = '0;
        B_in     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset busy", {31'd0, busy_out}, 32'd0);
        checkOutput("reset done", {31'd0, done_out}, 32'd0);
        checkOutput("reset result", result_out, 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expected, vecs[i].name, 0);
        end

        // start_in pulsed during CALC and during FIX must neither disturb the result nor queue a second operation.
        applyStimulus(2'b01, 32'd100, 32'd7, 32'd14, "start in CALC", 5);
        applyStimulus(2'b11, 32'd100, 32'd7, 32'd2, "start in FIX", LAT - 1);
        countDone(LAT + 5, pulses);
        checkOutput("no queued op", 32'(pulses), 32'd0);

        // A reset during CALC aborts the operation with no done pulse.
        @(negedge clk);
        start_in = 1'b1;
        op_in    = 2'b01;
        A_in     = 32'd1000;
        B_in     = 32'd3;
        @(negedge clk);
        start_in = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", {31'd0, busy_out}, 32'd0);
        checkOutput("abort done", {31'd0, done_out}, 32'd0);
        checkOutput("abort result cleared", result_out, 32'd0);
        rst = 1'b0;
        countDone(2 * LAT, pulses);
        checkOutput("abort no done", 32'(pulses), 32'd0);
        applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "after abort", 0);

        // start_in and rst high together: reset wins, so no operation starts.
        @(negedge clk);
        start_in = 1'b1;
        rst      = 1'b1;
        op_in    = 2'b01;
        A_in     = 32'd50;
        B_in     = 32'd5;
        @(negedge clk);
        start_in = 1'b0;
        rst      = 1'b0;
        checkOutput("start+rst busy", {31'd0, busy_out}, 32'd0);
        countDone(LAT + 5, pulses);
        checkOutput("start+rst no done", 32'(pulses), 32'd0);

        // Random operands against the reference model, spread over several magnitudes.
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom();
            rb  = $urandom() >> $urandom_range(0, 31);
            if (i == 5) rb = 32'd0;
            applyStimulus(rop, ra, rb, refModel(rop, ra, rb), "random", 0);
        end

        checkOutput("scoreboard empty", 32'(scoreboard.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
